// File: rtl/pcm_mm_arb.sv
// pcm_mm_arb: round-robin arbiter funnelling NUM_CPU request slots onto a single backing-memory port.
// Define PCM_MM_TIMEOUT_EN to build the BUSY-state timeout abort (reported on cpu_err).
module pcm_mm_arb #(
  parameter int NUM_CPU = 4,
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CPU-1:0]          cpu_req,
  input  logic [NUM_CPU-1:0]          cpu_write,
  input  logic [NUM_CPU*ADDR_W-1:0]   cpu_addr,
  input  logic [NUM_CPU*DATA_W-1:0]   cpu_data_in,
  output logic [NUM_CPU-1:0]          cpu_ready,
  output logic [NUM_CPU*DATA_W-1:0]   cpu_data_out,
  output logic [NUM_CPU-1:0]          cpu_err,
  output logic                        schedule,
  output logic [ADDR_W-1:0]           sched_addr,
  output logic                        sched_write,
  output logic [DATA_W-1:0]           sched_data,
  output logic [$clog2(NUM_CPU)-1:0]  sched_id,
  input  logic                        resolved,
  input  logic [DATA_W-1:0]           resolved_data
);

  localparam int IdW = $clog2(NUM_CPU);

  if (NUM_CPU < 2 || NUM_CPU > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("pcm_mm_arb: NUM_CPU must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t               state_q;
  logic [ADDR_W-1:0]    addr_q  [NUM_CPU];
  logic [DATA_W-1:0]    wdata_q [NUM_CPU];
  logic [DATA_W-1:0]    rdata_q [NUM_CPU];
  logic [NUM_CPU-1:0]   write_q;
  logic [NUM_CPU-1:0]   pending_q;
  logic [IdW-1:0]       last_grant_q;
  logic [IdW-1:0]       grant_q;
  logic [IdW-1:0]       grant_d;
  logic [IdW-1:0]       cand;
  logic                 found;
  logic [NUM_CPU-1:0]   ready_q;
  logic                 schedule_q;
  logic [ADDR_W-1:0]    sched_addr_q;
  logic                 sched_write_q;
  logic [DATA_W-1:0]    sched_data_q;

`ifdef PCM_MM_TIMEOUT_EN
  localparam int TmoW = $clog2(TIMEOUT + 1);
  logic [TmoW-1:0]      tmo_q;
  logic [NUM_CPU-1:0]   err_q;
`endif

  // Round-robin pick: first pending channel after the last one served.
  always_comb begin
    grant_d = last_grant_q;
    cand    = '0;
    found   = 1'b0;
    for (int k = 1; k <= NUM_CPU; k++) begin
      cand = IdW'((int'(last_grant_q) + k) % NUM_CPU);
      if (!found && pending_q[cand]) begin
        grant_d = cand;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      write_q       <= '0;
      last_grant_q  <= IdW'(NUM_CPU - 1);
      grant_q       <= '0;
      ready_q       <= '0;
      schedule_q    <= 1'b0;
      sched_addr_q  <= '0;
      sched_write_q <= 1'b0;
      sched_data_q  <= '0;
      for (int i = 0; i < NUM_CPU; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        rdata_q[i] <= '0;
      end
`ifdef PCM_MM_TIMEOUT_EN
      tmo_q <= '0;
      err_q <= '0;
`endif
    end else begin
      // A slot is only captured while free; the granted slot is always pending, so it never collides with the clear below.
      for (int i = 0; i < NUM_CPU; i++) begin
        if (cpu_req[i] && !pending_q[i]) begin
          addr_q[i]    <= cpu_addr[i*ADDR_W +: ADDR_W];
          wdata_q[i]   <= cpu_data_in[i*DATA_W +: DATA_W];
          write_q[i]   <= cpu_write[i];
          pending_q[i] <= 1'b1;
        end
      end
      ready_q <= '0;
`ifdef PCM_MM_TIMEOUT_EN
      err_q <= '0;
`endif
      unique case (state_q)
        IDLE: begin
          if (found) begin
            state_q       <= BUSY;
            grant_q       <= grant_d;
            schedule_q    <= 1'b1;
            sched_addr_q  <= addr_q[grant_d];
            sched_write_q <= write_q[grant_d];
            sched_data_q  <= wdata_q[grant_d];
`ifdef PCM_MM_TIMEOUT_EN
            tmo_q <= '0;
`endif
          end
        end
        BUSY: begin
          if (resolved) begin
            state_q          <= RESP;
            schedule_q       <= 1'b0;
            ready_q[grant_q] <= 1'b1;
            if (!sched_write_q) begin
              rdata_q[grant_q] <= resolved_data;
            end
          end
`ifdef PCM_MM_TIMEOUT_EN
          else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
            state_q          <= RESP;
            schedule_q       <= 1'b0;
            ready_q[grant_q] <= 1'b1;
            err_q[grant_q]   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        RESP: begin
          state_q            <= IDLE;
          pending_q[grant_q] <= 1'b0;
          last_grant_q       <= grant_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CPU; i++) begin : g_dout
    assign cpu_data_out[i*DATA_W +: DATA_W] = rdata_q[i];
  end

  assign cpu_ready   = ready_q;
  assign schedule    = schedule_q;
  assign sched_addr  = sched_addr_q;
  assign sched_write = sched_write_q;
  assign sched_data  = sched_data_q;
  assign sched_id    = grant_q;

`ifdef PCM_MM_TIMEOUT_EN
  assign cpu_err = err_q;
`else
  assign cpu_err = '0;
`endif

endmodule

// File: tb/tb_pcm_mm_arb.sv
// Scoreboard bench for pcm_mm_arb: expected grants and completions are queued by the stimulus,
// and a monitor compares them whenever schedule rises or cpu_ready pulses.
module tb_pcm_mm_arb;

   localparam int NUM_CPU = 4;
   localparam int ADDR_W  = 20;
   localparam int DATA_W  = 16;

   logic                       clk;
   logic                       reset;
   logic [NUM_CPU-1:0]         cpu_req;
   logic [NUM_CPU-1:0]         cpu_write;
   logic [NUM_CPU*ADDR_W-1:0]  cpu_addr;
   logic [NUM_CPU*DATA_W-1:0]  cpu_data_in;
   logic [NUM_CPU-1:0]         cpu_ready;
   logic [NUM_CPU*DATA_W-1:0]  cpu_data_out;
   logic [NUM_CPU-1:0]         cpu_err;
   logic                       schedule;
   logic [ADDR_W-1:0]          sched_addr;
   logic                       sched_write;
   logic [DATA_W-1:0]          sched_data;
   logic [1:0]                 sched_id;
   logic                       resolved;
   logic [DATA_W-1:0]          resolved_data;

   typedef struct {
      logic [1:0]        id;
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } schedExp_t;

   typedef struct {
      logic [1:0]        id;
      logic [DATA_W-1:0] data;
      logic              err;
   } readyExp_t;

   schedExp_t schedQ[$];
   readyExp_t readyQ[$];

   int checks = 0;
   int passes = 0;

   bit              respEnable = 1'b0;
   int              respDelay  = 1;
   logic [DATA_W-1:0] respBase = '0;

   pcm_mm_arb #(
      .NUM_CPU(NUM_CPU),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .TIMEOUT(8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_req      (cpu_req),
      .cpu_write    (cpu_write),
      .cpu_addr     (cpu_addr),
      .cpu_data_in  (cpu_data_in),
      .cpu_ready    (cpu_ready),
      .cpu_data_out (cpu_data_out),
      .cpu_err      (cpu_err),
      .schedule     (schedule),
      .sched_addr   (sched_addr),
      .sched_write  (sched_write),
      .sched_data   (sched_data),
      .sched_id     (sched_id),
      .resolved     (resolved),
      .resolved_data(resolved_data)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Absolute time limit so a stuck design still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic flagFail(input string name, input logic [31:0] act);
      checks++;
      $display("[TB] FAIL %s: got %h, expected no event", name, act);
   endtask

   task automatic setChannel(input int ch, input logic wr, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data);
      cpu_write[ch]                  = wr;
      cpu_addr[ch*ADDR_W +: ADDR_W]  = addr;
      cpu_data_in[ch*DATA_W +: DATA_W] = data;
   endtask

   // Pulses the request mask for exactly one rising edge; returns at the falling edge after it.
   task automatic applyStimulus(input logic [NUM_CPU-1:0] mask);
      @(negedge clk);
      cpu_req = mask;
      @(negedge clk);
      cpu_req = '0;
   endtask

   task automatic pushSched(input logic [1:0] id, input logic wr, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] data);
      schedExp_t s;
      s.id = id; s.write = wr; s.addr = addr; s.data = data;
      schedQ.push_back(s);
   endtask

   task automatic pushReady(input logic [1:0] id, input logic [DATA_W-1:0] data, input logic err);
      readyExp_t r;
      r.id = id; r.data = data; r.err = err;
      readyQ.push_back(r);
   endtask

   // Waits until every queued expectation has been consumed and the port is idle, within a cycle budget.
   task automatic waitDrain(input int maxCycles);
      int n;
      n = 0;
      while ((schedQ.size() != 0 || readyQ.size() != 0 || schedule) && n < maxCycles) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= maxCycles) flagFail("drain_timeout", 32'(readyQ.size()));
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic doReset();
      reset   = 1'b0;
      cpu_req = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Backing-memory model: answers respDelay cycles after schedule rises with respBase + sched_id.
   initial begin
      int busyCnt;
      busyCnt       = 0;
      resolved      = 1'b0;
      resolved_data = '0;
      forever begin
         @(negedge clk);
         if (respEnable) begin
            if (schedule) begin
               if (busyCnt == respDelay - 1) begin
                  resolved      = 1'b1;
                  resolved_data = respBase + DATA_W'(sched_id);
               end else begin
                  resolved = 1'b0;
               end
               busyCnt++;
            end else begin
               resolved = 1'b0;
               busyCnt  = 0;
            end
         end else begin
            busyCnt = 0;
         end
      end
   end

   // Monitor: compares each new grant and each completion pulse against the head of its queue.
   initial begin
      logic      prevSched;
      schedExp_t s;
      readyExp_t r;
      logic [3:0] oneHot;
      prevSched = 1'b0;
      forever begin
         @(negedge clk);
         if (reset && schedule && !prevSched) begin
            if (schedQ.size() == 0) begin
               flagFail("sched_unexpected", 32'(sched_id));
            end else begin
               s = schedQ.pop_front();
               checkOutput("sched_id", 32'(sched_id), 32'(s.id));
               checkOutput("sched_write", 32'(sched_write), 32'(s.write));
               checkOutput("sched_addr", 32'(sched_addr), 32'(s.addr));
               checkOutput("sched_data", 32'(sched_data), 32'(s.data));
            end
         end
         prevSched = schedule;
         if (cpu_ready != '0) begin
            if (readyQ.size() == 0) begin
               flagFail("ready_spurious", 32'(cpu_ready));
            end else begin
               r = readyQ.pop_front();
               oneHot = 4'b0001 << r.id;
               checkOutput("ready_onehot", 32'(cpu_ready), 32'(oneHot));
               checkOutput("ready_data", 32'(cpu_data_out[r.id*DATA_W +: DATA_W]), 32'(r.data));
               checkOutput("ready_err", 32'(cpu_err), r.err ? 32'(oneHot) : 32'h0);
            end
         end
      end
   end

   initial begin
      reset         = 1'b0;
      cpu_req       = '0;
      cpu_write     = '0;
      cpu_addr      = '0;
      cpu_data_in   = '0;

      // Reset state while reset is held low.
      #1;
      checkOutput("rst_schedule", 32'(schedule), 32'h0);
      checkOutput("rst_ready", 32'(cpu_ready), 32'h0);
      checkOutput("rst_err", 32'(cpu_err), 32'h0);
      checkOutput("rst_data_out", 32'(cpu_data_out[31:0]), 32'h0);
      checkOutput("rst_data_out_hi", 32'(cpu_data_out[63:32]), 32'h0);
      checkOutput("rst_sched_addr", 32'(sched_addr), 32'h0);
      checkOutput("rst_sched_write", 32'(sched_write), 32'h0);
      checkOutput("rst_sched_data", 32'(sched_data), 32'h0);
      checkOutput("rst_sched_id", 32'(sched_id), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Single read on channel 0 with latency checkpoints.
      $display("[TB] single read ch0");
      respEnable = 1'b1; respDelay = 1; respBase = 16'h0101;
      setChannel(0, 1'b0, 20'h00000, 16'h0000);
      pushSched(2'd0, 1'b0, 20'h00000, 16'h0000);
      pushReady(2'd0, 16'h0101, 1'b0);
      applyStimulus(4'b0001);
      checkOutput("lat_sched_after_e0", 32'(schedule), 32'h0);
      @(negedge clk);
      checkOutput("lat_sched_after_e1", 32'(schedule), 32'h1);
      checkOutput("lat_ready_after_e1", 32'(cpu_ready), 32'h0);
      waitDrain(50);

      // Read then write on channel 2; the write must leave the read data in place.
      $display("[TB] read then write ch2");
      setChannel(2, 1'b0, 20'h00222, 16'h0000);
      pushSched(2'd2, 1'b0, 20'h00222, 16'h0000);
      pushReady(2'd2, 16'h0103, 1'b0);
      applyStimulus(4'b0100);
      waitDrain(50);
      respBase = 16'h0201;
      setChannel(2, 1'b1, 20'hFFFFF, 16'h0FF0);
      pushSched(2'd2, 1'b1, 20'hFFFFF, 16'h0FF0);
      pushReady(2'd2, 16'h0103, 1'b0);
      applyStimulus(4'b0100);
      waitDrain(50);

      // Contention from reset: order 0,1,2,3 then 0,1.
      $display("[TB] contention");
      doReset();
      respDelay = 2; respBase = 16'hC000;
      for (int i = 0; i < NUM_CPU; i++) begin
         setChannel(i, 1'b0, 20'h0A000 + ADDR_W'(i), 16'h0000);
         pushSched(2'(i), 1'b0, 20'h0A000 + ADDR_W'(i), 16'h0000);
         pushReady(2'(i), 16'hC000 + DATA_W'(i), 1'b0);
      end
      applyStimulus(4'b1111);
      waitDrain(200);
      setChannel(0, 1'b1, 20'h0B000, 16'hB0B0);
      setChannel(1, 1'b1, 20'h0B001, 16'hB1B1);
      pushSched(2'd0, 1'b1, 20'h0B000, 16'hB0B0);
      pushSched(2'd1, 1'b1, 20'h0B001, 16'hB1B1);
      pushReady(2'd0, 16'hC000, 1'b0);
      pushReady(2'd1, 16'hC001, 1'b0);
      applyStimulus(4'b0011);
      waitDrain(100);

      // Ignore rules: resolved in IDLE, and a second ch1 request while pending.
      $display("[TB] ignore rules");
      respEnable = 1'b0;
      @(negedge clk);
      resolved = 1'b1; resolved_data = 16'hDEAD;
      @(negedge clk);
      resolved = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("idle_resolved_sched", 32'(schedule), 32'h0);
      setChannel(0, 1'b0, 20'h00100, 16'h0000);
      pushSched(2'd0, 1'b0, 20'h00100, 16'h0000);
      pushReady(2'd0, 16'h5A00, 1'b0);
      applyStimulus(4'b0001);
      setChannel(1, 1'b0, 20'h11111, 16'h1111);
      pushSched(2'd1, 1'b0, 20'h11111, 16'h1111);
      pushReady(2'd1, 16'h5A01, 1'b0);
      applyStimulus(4'b0010);
      setChannel(1, 1'b1, 20'h99999, 16'h9999);
      applyStimulus(4'b0010);
      respDelay = 1; respBase = 16'h5A00; respEnable = 1'b1;
      waitDrain(100);

      // Reset while BUSY: schedule drops at once and nothing completes afterwards.
      $display("[TB] reset mid-busy");
      respEnable = 1'b0;
      setChannel(0, 1'b0, 20'h00AAA, 16'h0000);
      setChannel(3, 1'b1, 20'h33333, 16'h3333);
      pushSched(2'd3, 1'b1, 20'h33333, 16'h3333);
      applyStimulus(4'b1001);
      @(negedge clk);
      checkOutput("rstbusy_sched_before", 32'(schedule), 32'h1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("rstbusy_sched_async", 32'(schedule), 32'h0);
      checkOutput("rstbusy_data_cleared", 32'(cpu_data_out[31:0]), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      checkOutput("rstbusy_no_regrant", 32'(schedule), 32'h0);
      checkOutput("rstbusy_schedQ_empty", 32'(schedQ.size()), 32'h0);

`ifdef PCM_MM_TIMEOUT_EN
      // Timeout abort after 8 BUSY cycles, then a normal transaction on the same channel.
      $display("[TB] timeout");
      respEnable = 1'b1; respDelay = 1; respBase = 16'h7700;
      setChannel(2, 1'b0, 20'h22222, 16'h0000);
      pushSched(2'd2, 1'b0, 20'h22222, 16'h0000);
      pushReady(2'd2, 16'h7702, 1'b0);
      applyStimulus(4'b0100);
      waitDrain(50);
      respEnable = 1'b0;
      pushSched(2'd2, 1'b0, 20'h22222, 16'h0000);
      pushReady(2'd2, 16'h7702, 1'b1);
      applyStimulus(4'b0100);
      repeat (8) @(negedge clk);
      checkOutput("tmo_still_busy", 32'(schedule), 32'h1);
      checkOutput("tmo_no_early_ready", 32'(cpu_ready), 32'h0);
      waitDrain(50);
      respEnable = 1'b1; respBase = 16'h7710;
      pushSched(2'd2, 1'b0, 20'h22222, 16'h0000);
      pushReady(2'd2, 16'h7712, 1'b0);
      applyStimulus(4'b0100);
      waitDrain(50);
`endif

      checkOutput("end_schedQ_empty", 32'(schedQ.size()), 32'h0);
      checkOutput("end_readyQ_empty", 32'(readyQ.size()), 32'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
